fetch_queue_ctrl: RTL and testbench
===================================

# fetch_queue_ctrl

Controller for the multi-channel instruction queue between fetch and decode. It decides how many entries the queue accepts per cycle (all-or-nothing per fetch group) and how many it releases to decode. It mirrors queue occupancy in its own counter and sequences pipeline flushes, including a bubble window that discards stale in-flight fetch groups. It drives only the queue's push_num/pop_num/flush; the data lanes connect directly from fetch to the queue to decode.

## Interface
Parameters:
- CHANNEL, 4, queue lanes (max entries pushed per cycle)
- DEPTH, 2, entries per lane; capacity CAP = CHANNEL*DEPTH
- ISSUE_WIDTH, 2, max entries popped per cycle (≤ CHANNEL)
- FLUSH_CYCLES, 2, stale-fetch discard window after a flush (≥1)

Ports (CW = $clog2(CAP+1), FW = $clog2(CHANNEL+1), IW = $clog2(ISSUE_WIDTH+1)):
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- flush_req  in  1  pipeline redirect; flush queue now
- fetch_valid  in  1  fetch offers a group this cycle
- fetch_num  in  FW  entries in offered group (0..CHANNEL)
- fetch_ready  out  1  group accepted (valid&ready = handshake)
- decode_req  in  IW  entries decode can take this cycle
- decode_avail  out  IW  min(occupancy, ISSUE_WIDTH), 0 outside RUN
- queue_push_num  out  FW  to queue push_num
- queue_pop_num  out  IW  to queue pop_num
- queue_flush  out  1  to queue flush
- occupancy  out  CW  registered entry count

## Operation
- States: RUN, DISCARD. Reset enters RUN with occ=0, discard counter=0.
- While rst=1: queue_flush=1; fetch_ready, queue_push_num, queue_pop_num, decode_avail = 0; next occ=0, next state RUN.
- eff_num = min(fetch_num, CHANNEL). Values above CHANNEL are clamped, never an error.
- RUN, flush_req=0:
  - free = CAP − occ, from the registered occ only. Same-cycle pops do not create space.
  - fetch_ready = (eff_num ≤ free). Ready is independent of fetch_valid.
  - queue_push_num = fetch_valid & fetch_ready ? eff_num : 0. A group is never split. fetch_valid with fetch_num=0 is a legal no-op handshake.
  - queue_pop_num = min(decode_req, occ, ISSUE_WIDTH). Entries pushed this cycle are not poppable this cycle.
  - occ_next = occ + push − pop. occ never exceeds CAP and never goes below 0.
- flush_req=1, in any state: queue_flush=1; push, pop, fetch_ready, decode_avail = 0; occ_next=0; state → DISCARD; discard counter loaded with FLUSH_CYCLES.
- DISCARD, flush_req=0:
  - fetch_ready=1 and queue_push_num=0. Stale groups are consumed and dropped.
  - queue_pop_num=0, decode_avail=0, queue_flush=0.
  - Counter decrements each cycle. The cycle in which it reads 1 is the last DISCARD cycle; state → RUN next.
  - flush_req during DISCARD restarts the window at FLUSH_CYCLES.
- Priority: rst > flush_req > normal operation.

## Timing
- All outputs are combinational from registered state plus current inputs. Zero-cycle handshake.
- Push accepted in cycle N is visible in occupancy and decode_avail at N+1. This gives a 1-cycle fetch→decode latency through the controller.
- A flush asserted at cycle N discards fetch groups handshaken at N+1 .. N+FLUSH_CYCLES. The first accepting RUN cycle is N+FLUSH_CYCLES+1.
- Full boundary: with occ=CAP, fetch_ready=1 only for eff_num=0. With occ=CAP−1, a 1-entry group is accepted and a 2-entry group stalls, even if a pop occurs that cycle.
- Empty boundary: with occ=0, queue_pop_num=0 regardless of decode_req.
- Reset mid-operation (including mid-DISCARD): next cycle is RUN with occ=0.

## Test plan
Defaults CHANNEL=4, DEPTH=2, ISSUE_WIDTH=2, FLUSH_CYCLES=2.
- Reset, then push groups of 1, 2, 3, no pops → push_num 1, 2, 3 accepted; occupancy 1, 3, 6; then a group of 4 → fetch_ready=0, push_num=0, occ stays 6; a group of 2 → accepted, occ=8.
- occ=8, decode_req=2 each cycle with fetch_valid, fetch_num=1 → first cycle fetch_ready=0 and pop_num=2 (occ 6); next cycle push 1 and pop 2 (occ 5).
- occ=1, decode_req=2 → pop_num=1, decode_avail was 1, occ→0; next cycle pop_num=0.
- occ=5, flush_req at cycle N with fetch_valid, fetch_num=3 held → N: queue_flush=1, fetch_ready=0; N+1, N+2: fetch_ready=1, push_num=0, occ=0; N+3: push_num=3, occ→3.
- flush_req at N and again at N+1 → discard window ends after N+3; first push at N+4.
- rst at the second DISCARD cycle → queue_flush=1 that cycle; next cycle RUN, occ=0, push accepted.
- fetch_num=7 with occ=0 → clamped, push_num=4.

Source files
------------

// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: fetch->decode queue push/pop/flush controller with occupancy mirror and post-flush discard window
module fetch_queue_ctrl #(
  parameter int CHANNEL = 4,
  parameter int DEPTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int FLUSH_CYCLES = 2,
  localparam int CAP = CHANNEL * DEPTH,
  localparam int CW = $clog2(CAP + 1),
  localparam int FW = $clog2(CHANNEL + 1),
  localparam int IW = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_req,
  input  logic          fetch_valid,
  input  logic [FW-1:0] fetch_num,
  output logic          fetch_ready,
  input  logic [IW-1:0] decode_req,
  output logic [IW-1:0] decode_avail,
  output logic [FW-1:0] queue_push_num,
  output logic [IW-1:0] queue_pop_num,
  output logic          queue_flush,
  output logic [CW-1:0] occupancy
);
  localparam int DW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic {RUN, DISCARD} state_t;
  state_t state, state_next;
  logic [CW-1:0] occ, occ_next, free;
  logic [DW-1:0] cnt, cnt_next;
  logic [FW-1:0] eff;
  logic [IW-1:0] req_c, pop, avail;
  logic fits;
  assign eff = (fetch_num > FW'(CHANNEL)) ? FW'(CHANNEL) : fetch_num;
  // free space comes from registered occupancy only; same-cycle pops never make room
  assign free = CW'(CAP) - occ;
  assign fits = CW'(eff) <= free;
  assign req_c = (decode_req > IW'(ISSUE_WIDTH)) ? IW'(ISSUE_WIDTH) : decode_req;
  assign pop = (CW'(req_c) <= occ) ? req_c : IW'(occ);
  assign avail = (occ >= CW'(ISSUE_WIDTH)) ? IW'(ISSUE_WIDTH) : IW'(occ);
  assign occupancy = occ;
  always_comb begin
    state_next = state;
    occ_next = occ;
    cnt_next = cnt;
    fetch_ready = 1'b0;
    queue_push_num = '0;
    queue_pop_num = '0;
    decode_avail = '0;
    queue_flush = 1'b0;
    if (rst) begin
      queue_flush = 1'b1;
      occ_next = '0;
      cnt_next = '0;
      state_next = RUN;
    end else if (flush_req) begin
      queue_flush = 1'b1;
      occ_next = '0;
      cnt_next = DW'(FLUSH_CYCLES);
      state_next = DISCARD;
    end else if (state == DISCARD) begin
      // stale in-flight groups are handshaken but never written
      fetch_ready = 1'b1;
      cnt_next = cnt - 1'b1;
      state_next = (cnt == DW'(1)) ? RUN : DISCARD;
    end else begin
      fetch_ready = fits;
      queue_push_num = (fetch_valid && fits) ? eff : '0;
      queue_pop_num = pop;
      decode_avail = avail;
      occ_next = occ + CW'(queue_push_num) - CW'(queue_pop_num);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      occ <= '0;
      cnt <= '0;
    end else begin
      state <= state_next;
      occ <= occ_next;
      cnt <= cnt_next;
    end
  end
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb_fetch_queue_ctrl: directed self-checking bench for fetch_queue_ctrl
module tb_fetch_queue_ctrl;
  logic clk = 1'b0;
  logic rst, flush_req, fetch_valid, fetch_ready, queue_flush;
  logic [2:0] fetch_num, queue_push_num;
  logic [1:0] decode_req, decode_avail, queue_pop_num;
  logic [3:0] occupancy;
  int checks = 0;
  int errors = 0;
  fetch_queue_ctrl dut (
    .clk(clk),
    .rst(rst),
    .flush_req(flush_req),
    .fetch_valid(fetch_valid),
    .fetch_num(fetch_num),
    .fetch_ready(fetch_ready),
    .decode_req(decode_req),
    .decode_avail(decode_avail),
    .queue_push_num(queue_push_num),
    .queue_pop_num(queue_pop_num),
    .queue_flush(queue_flush),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic r, input logic f, input logic v, input int n, input int q);
    rst = r;
    flush_req = f;
    fetch_valid = v;
    fetch_num = 3'(n);
    decode_req = 2'(q);
    #1;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input int rdy, input int push, input int pop, input int occ_after);
    check({tag, "_ready"}, int'(fetch_ready), rdy);
    check({tag, "_push"}, int'(queue_push_num), push);
    check({tag, "_pop"}, int'(queue_pop_num), pop);
    cyc();
    check({tag, "_occ"}, int'(occupancy), occ_after);
  endtask
  initial begin
    @(posedge clk);
    #1;
    drive(1, 0, 1, 1, 2);
    check("rst_flush", int'(queue_flush), 1);
    check("rst_ready", int'(fetch_ready), 0);
    check("rst_push", int'(queue_push_num), 0);
    check("rst_avail", int'(decode_avail), 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    check("reset_occ", int'(occupancy), 0);
    check("reset_qflush", int'(queue_flush), 0);
    drive(0, 0, 1, 1, 0); run("push1", 1, 1, 0, 1);
    drive(0, 0, 1, 2, 0); run("push2", 1, 2, 0, 3);
    drive(0, 0, 1, 3, 0); run("push3", 1, 3, 0, 6);
    drive(0, 0, 1, 4, 0); run("push4_stall", 0, 0, 0, 6);
    drive(0, 0, 1, 2, 0); run("push2_fill", 1, 2, 0, 8);
    drive(0, 0, 1, 1, 2);
    check("full_avail", int'(decode_avail), 2);
    run("full_pop", 0, 0, 2, 6);
    drive(0, 0, 1, 1, 2); run("push_pop", 1, 1, 2, 5);
    drive(0, 0, 1, 2, 0); run("to7", 1, 2, 0, 7);
    drive(0, 0, 1, 2, 2); run("cap1_grp2", 0, 0, 2, 5);
    drive(0, 0, 1, 2, 0); run("to7b", 1, 2, 0, 7);
    drive(0, 0, 1, 1, 0); run("cap1_grp1", 1, 1, 0, 8);
    drive(0, 0, 1, 0, 0);
    check("full_zero_ready", int'(fetch_ready), 1);
    check("full_zero_push", int'(queue_push_num), 0);
    drive(0, 0, 0, 0, 2); run("drain_a", 1, 0, 2, 6);
    drive(0, 0, 0, 0, 1); run("drain_b", 1, 0, 1, 5);
    drive(0, 0, 0, 0, 2); run("drain_c", 1, 0, 2, 3);
    drive(0, 0, 0, 0, 2); run("drain_d", 1, 0, 2, 1);
    drive(0, 0, 0, 0, 2);
    check("occ1_avail", int'(decode_avail), 1);
    run("occ1_pop", 1, 0, 1, 0);
    drive(0, 0, 0, 0, 2);
    check("empty_pop", int'(queue_pop_num), 0);
    check("empty_avail", int'(decode_avail), 0);
    drive(0, 0, 1, 4, 0); run("fill4", 1, 4, 0, 4);
    drive(0, 0, 1, 1, 0); run("fill5", 1, 1, 0, 5);
    drive(0, 1, 1, 3, 2);
    check("fl_qflush", int'(queue_flush), 1);
    check("fl_avail", int'(decode_avail), 0);
    run("fl_n", 0, 0, 0, 0);
    drive(0, 0, 1, 3, 2);
    check("fl_n1_qflush", int'(queue_flush), 0);
    check("fl_n1_avail", int'(decode_avail), 0);
    run("fl_n1", 1, 0, 0, 0);
    run("fl_n2", 1, 0, 0, 0);
    run("fl_n3", 1, 3, 0, 3);
    drive(0, 1, 1, 3, 0); run("dfl_n", 0, 0, 0, 0);
    drive(0, 1, 1, 3, 0);
    check("dfl_n1_qflush", int'(queue_flush), 1);
    run("dfl_n1", 0, 0, 0, 0);
    drive(0, 0, 1, 3, 0); run("dfl_n2", 1, 0, 0, 0);
    run("dfl_n3", 1, 0, 0, 0);
    run("dfl_n4", 1, 3, 0, 3);
    drive(0, 1, 1, 3, 0); run("rfl_n", 0, 0, 0, 0);
    drive(0, 0, 1, 3, 0); run("rfl_n1", 1, 0, 0, 0);
    drive(1, 0, 1, 3, 0);
    check("rfl_rst_qflush", int'(queue_flush), 1);
    run("rfl_rst", 0, 0, 0, 0);
    drive(0, 0, 1, 3, 0); run("rfl_after", 1, 3, 0, 3);
    drive(0, 0, 0, 0, 2); run("dr2a", 1, 0, 2, 1);
    drive(0, 0, 0, 0, 2); run("dr2b", 1, 0, 1, 0);
    drive(0, 0, 1, 7, 0); run("clamp7", 1, 4, 0, 4);
    drive(0, 0, 0, 0, 3);
    check("req_clamp_avail", int'(decode_avail), 2);
    run("req_clamp", 1, 0, 2, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
